// File: rtl/pc_unit_ext.sv
// pc_unit_ext: fetch-stage program counter with stall hold, exception redirect
// and a one-entry redirect buffer. A redirect that arrives while the PC is
// frozen is parked in the buffer and applied on the first unstalled edge.
module pc_unit_ext #(
    parameter int                ADDR_W    = 16,
    parameter int                PC_STEP   = 2,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'('h4),
    parameter int                STALL_W   = 6,
    parameter int                STALL_BIT = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall_i,
    input  logic               jump_i,
    input  logic [ADDR_W-1:0]  jump_target_i,
    input  logic               exc_i,
    output logic [ADDR_W-1:0]  pc_o,
    output logic               ce_o,
    output logic               in_delay_slot_o,
    output logic               pend_o
);

    typedef enum logic {
        S_BOOT,
        S_RUN
    } state_e;

    // Kind of a parked redirect; a JUMP makes the next fetch a delay slot.
    typedef enum logic {
        K_JUMP,
        K_EXC
    } kind_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ds_q, ds_d;
    logic              buf_vld_q, buf_vld_d;
    kind_e             buf_kind_q, buf_kind_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;

    logic              hold;
    logic [ADDR_W-1:0] pc_seq;

    // Only one stall bit freezes the PC; the rest belong to other stages.
    assign hold   = stall_i[STALL_BIT];
    assign pc_seq = pc_q + ADDR_W'(PC_STEP);

    logic unused_stall;
    assign unused_stall = ^stall_i;

    // State and datapath registers; reset overrides stall and pending redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_VEC;
            ds_q       <= 1'b0;
            buf_vld_q  <= 1'b0;
            buf_kind_q <= K_JUMP;
            buf_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ds_q       <= ds_d;
            buf_vld_q  <= buf_vld_d;
            buf_kind_q <= buf_kind_d;
            buf_addr_q <= buf_addr_d;
        end
    end

    // Next PC selection: exc > pending > jump > sequential, or capture while held.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ds_d       = ds_q;
        buf_vld_d  = buf_vld_q;
        buf_kind_d = buf_kind_q;
        buf_addr_d = buf_addr_q;

        case (state_q)
            S_BOOT: begin
                // First fetch uses RESET_VEC unchanged; inputs are not sampled here.
                state_d = S_RUN;
            end
            S_RUN: begin
                if (!hold) begin
                    if (exc_i) begin
                        pc_d      = EXC_VEC;
                        ds_d      = 1'b0;
                        buf_vld_d = 1'b0;
                    end else if (buf_vld_q) begin
                        // A jump arriving now comes from the flushed ID and is dropped.
                        pc_d      = buf_addr_q;
                        ds_d      = (buf_kind_q == K_JUMP);
                        buf_vld_d = 1'b0;
                    end else if (jump_i) begin
                        pc_d = jump_target_i;
                        ds_d = 1'b1;
                    end else begin
                        pc_d = pc_seq;
                        ds_d = 1'b0;
                    end
                end else begin
                    if (exc_i) begin
                        buf_vld_d  = 1'b1;
                        buf_kind_d = K_EXC;
                        buf_addr_d = EXC_VEC;
                    end else if (jump_i && !buf_vld_q) begin
                        buf_vld_d  = 1'b1;
                        buf_kind_d = K_JUMP;
                        buf_addr_d = jump_target_i;
                    end
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    assign pc_o            = pc_q;
    assign ce_o            = (state_q == S_RUN);
    assign in_delay_slot_o = ds_q;
    assign pend_o          = buf_vld_q;

endmodule
